round_cipher_stage: RTL

- Round-based cipher core that consumes the 16-bit word and done pulse produced by the first pipeline stage.
- Runs a fixed number of XOR/rotate/add rounds keyed by the 5-bit key, then presents a 17-bit result to the next stage: carry flag in bit 16, data in bits 15:0.
- Uses a valid/ready handshake on both sides and holds its result until the downstream stage accepts it.

---
 rtl/round_cipher_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/round_cipher_stage.sv
// Round-based XOR/rotate/add cipher stage with valid/ready on both sides.
// Result is {carry_flag, data}; held until the downstream stage accepts it.
module round_cipher_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned KEY_W  = 5,
    parameter int unsigned ROUNDS = 4
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key_bits,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned OUT_W = DATA_W + 1;
    localparam logic [CNT_W-1:0] LAST_R = CNT_W'(ROUNDS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [KEY_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0]  r_q, r_d;
    logic              carry_q, carry_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0]   k16_c;
    logic [DATA_W-1:0]   t_c;
    logic [CNT_W-1:0]    rot_amt_c;
    logic [2*DATA_W-1:0] dbl_c;
    logic [DATA_W-1:0]   t2_c;
    logic [OUT_W-1:0]    s_c;

    // One cipher round on the current word; rotate via doubled-word shift.
    always_comb begin
        k16_c     = {k_q, k_q, k_q, k_q[KEY_W-1]};
        t_c       = d_q ^ k16_c;
        rot_amt_c = k_q[CNT_W-1:0] + r_q;
        dbl_c     = {t_c, t_c} << rot_amt_c;
        t2_c      = dbl_c[2*DATA_W-1:DATA_W];
        s_c       = {1'b0, t2_c} + OUT_W'(k_q) + OUT_W'(r_q);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        k_d         = k_q;
        r_d         = r_q;
        carry_d     = carry_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    d_d        = in_data;
                    k_d        = key_bits;
                    r_d        = '0;
                    carry_d    = 1'b0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_ROUND;
                end
            end
            S_ROUND: begin
                d_d     = s_c[DATA_W-1:0];
                carry_d = carry_q | s_c[DATA_W];
                r_d     = r_q + CNT_W'(1);
                if (r_q == LAST_R) begin
                    out_data_d  = {carry_q | s_c[DATA_W], s_c[DATA_W-1:0]};
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            d_q         <= '0;
            k_q         <= '0;
            r_q         <= '0;
            carry_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            k_q         <= k_d;
            r_q         <= r_d;
            carry_q     <= carry_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
